round_ctrl: RTL and testbench

Round controller for the reflex trainer; sits directly downstream of the ball position generator. It pulses `new_ball` to request a target, then consumes the `ballX`/`ballY` it produces. In each round it checks cursor clicks against the 40x40 ball box, or times the round out, and measures reaction time in milliseconds. It also keeps score over a fixed number of rounds.

---
 rtl/round_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_round_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_ctrl.sv
// round_ctrl
// Round controller for the reflex trainer. Requests a ball from the
// position generator, waits one cycle for it to settle, and then runs a
// timed round. A round ends on a click inside the ball box (a hit) or
// when the millisecond counter reaches the timeout (a miss). The block
// keeps score, the last and best reaction times, and the count of
// completed rounds for a game of ROUNDS rounds.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             single-cycle pulse, begins a game from IDLE or DONE
//   click             single-cycle mouse click pulse
//   cursorX, cursorY  cursor pixel position
//   ballX, ballY      ball top-left corner from the generator
//   new_ball          one-cycle request for a new ball position (SPAWN)
//   ball_visible      high while the round is live (ACTIVE)
//   score             hits this game, saturating at 255
//   round_cnt         completed rounds this game
//   last_rt           reaction time of the last round in ms (TIMEOUT_MS on a miss)
//   best_rt           fastest hit this game in ms, 1023 when there has been no hit
//   game_over         high once all rounds are complete (DONE)
//
// Configuration macro:
//   MISS_PENALTY_EN   when defined, a timeout takes one point off the score
//                     (saturating at 0); otherwise a timeout leaves it alone.

module round_ctrl #(
   parameter int TICK_DIV   = 25000,
   parameter int BALL_SIZE  = 40,
   parameter int TIMEOUT_MS = 1000,
   parameter int ROUNDS     = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       click,
   input  logic [9:0] cursorX,
   input  logic [9:0] cursorY,
   input  logic [9:0] ballX,
   input  logic [9:0] ballY,
   output logic       new_ball,
   output logic       ball_visible,
   output logic [7:0] score,
   output logic [4:0] round_cnt,
   output logic [9:0] last_rt,
   output logic [9:0] best_rt,
   output logic       game_over
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      SETTLE,
      ACTIVE,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [9:0]    ms_q, ms_d;
   logic [7:0]    score_q, score_d;
   logic [4:0]    round_q, round_d;
   logic [9:0]    lastRt_q, lastRt_d;
   logic [9:0]    bestRt_q, bestRt_d;

   logic       inBox;
   logic       hit;
   logic       timeout;
   logic       roundEnd;
   logic [4:0] roundNext;

   // The box test widens everything to 11 bits so that a ball near the
   // right or bottom screen edge cannot wrap its far edge back to zero.
   assign inBox = ({1'b0, cursorX} >= {1'b0, ballX}) &&
                  ({1'b0, cursorX} <  ({1'b0, ballX} + 11'(BALL_SIZE))) &&
                  ({1'b0, cursorY} >= {1'b0, ballY}) &&
                  ({1'b0, cursorY} <  ({1'b0, ballY} + 11'(BALL_SIZE)));

   // A hit takes priority over a timeout landing in the same cycle.
   assign hit       = (state_q == ACTIVE) && click && inBox;
   assign timeout   = (state_q == ACTIVE) && (ms_q == 10'(TIMEOUT_MS));
   assign roundEnd  = hit || timeout;
   assign roundNext = round_q + 5'd1;

   // Next-state logic: game setup on start, round timing in ACTIVE, and
   // the score/reaction-time bookkeeping when a round ends.
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      ms_d     = ms_q;
      score_d  = score_q;
      round_d  = round_q;
      lastRt_d = lastRt_q;
      bestRt_d = bestRt_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               score_d  = 8'd0;
               round_d  = 5'd0;
               lastRt_d = 10'd0;
               bestRt_d = 10'd1023;
               state_d  = SPAWN;
            end
         end
         SPAWN: begin
            state_d = SETTLE;
         end
         SETTLE: begin
            presc_d = '0;
            ms_d    = 10'd0;
            state_d = ACTIVE;
         end
         ACTIVE: begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
               presc_d = '0;
               if (ms_q != 10'd1023) begin
                  ms_d = ms_q + 10'd1;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end

            if (hit) begin
               if (score_q != 8'd255) begin
                  score_d = score_q + 8'd1;
               end
               lastRt_d = ms_q;
               if (ms_q < bestRt_q) begin
                  bestRt_d = ms_q;
               end
            end else if (timeout) begin
               lastRt_d = 10'(TIMEOUT_MS);
`ifdef MISS_PENALTY_EN
               if (score_q != 8'd0) begin
                  score_d = score_q - 8'd1;
               end
`else
               score_d = score_q;
`endif
            end

            if (roundEnd) begin
               round_d = roundNext;
               state_d = (roundNext == 5'(ROUNDS)) ? DONE : SPAWN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers; reset drops straight back to IDLE with
   // the score registers at their power-up values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         ms_q     <= 10'd0;
         score_q  <= 8'd0;
         round_q  <= 5'd0;
         lastRt_q <= 10'd0;
         bestRt_q <= 10'd1023;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         ms_q     <= ms_d;
         score_q  <= score_d;
         round_q  <= round_d;
         lastRt_q <= lastRt_d;
         bestRt_q <= bestRt_d;
      end
   end

   assign new_ball     = (state_q == SPAWN);
   assign ball_visible = (state_q == ACTIVE);
   assign game_over    = (state_q == DONE);
   assign score        = score_q;
   assign round_cnt    = round_q;
   assign last_rt      = lastRt_q;
   assign best_rt      = bestRt_q;

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl
// Directed bench for round_ctrl with TICK_DIV=4, BALL_SIZE=40,
// TIMEOUT_MS=5, ROUNDS=3. Inputs change 1 time unit after a rising edge
// and outputs are checked at the same point, so every check sees the
// state produced by the edge just taken.

module tb_round_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       click = 1'b0;
   logic [9:0] cursorX = '0;
   logic [9:0] cursorY = '0;
   logic [9:0] ballX = '0;
   logic [9:0] ballY = '0;
   logic       new_ball;
   logic       ball_visible;
   logic [7:0] score;
   logic [4:0] round_cnt;
   logic [9:0] last_rt;
   logic [9:0] best_rt;
   logic       game_over;

   int compared   = 0;
   int mismatched = 0;

`ifdef MISS_PENALTY_EN
   localparam int SCORE_AFTER_MISS = 0;
`else
   localparam int SCORE_AFTER_MISS = 1;
`endif

   round_ctrl #(
      .TICK_DIV  (4),
      .BALL_SIZE (40),
      .TIMEOUT_MS(5),
      .ROUNDS    (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .click       (click),
      .cursorX     (cursorX),
      .cursorY     (cursorY),
      .ballX       (ballX),
      .ballY       (ballY),
      .new_ball    (new_ball),
      .ball_visible(ball_visible),
      .score       (score),
      .round_cnt   (round_cnt),
      .last_rt     (last_rt),
      .best_rt     (best_rt),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle just past the last one.
   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive the pulse inputs and cursor for the next sampling edge.
   task automatic applyStimulus(input logic s, input logic c,
                                input int cx, input int cy);
      start   = s;
      click   = c;
      cursorX = 10'(cx);
      cursorY = 10'(cy);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Checks every output against its reset value.
   task automatic checkReset(input string tag);
      checkOutput({tag, ".new_ball"}, 32'(new_ball), 0);
      checkOutput({tag, ".ball_visible"}, 32'(ball_visible), 0);
      checkOutput({tag, ".score"}, 32'(score), 0);
      checkOutput({tag, ".round_cnt"}, 32'(round_cnt), 0);
      checkOutput({tag, ".last_rt"}, 32'(last_rt), 0);
      checkOutput({tag, ".best_rt"}, 32'(best_rt), 1023);
      checkOutput({tag, ".game_over"}, 32'(game_over), 0);
   endtask

   // Guards against the directed sequence ever stalling.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      ballX = 10'd100;
      ballY = 10'd200;

      // Reset and idle
      rst = 1'b1;
      waitCycles(2);
      checkReset("reset");
      rst = 1'b0;
      waitCycles(1);
      checkOutput("idle.new_ball", 32'(new_ball), 0);

      // Start: SPAWN, SETTLE, then ACTIVE
      applyStimulus(1'b1, 1'b0, 0, 0);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("spawn.new_ball", 32'(new_ball), 1);
      checkOutput("spawn.ball_visible", 32'(ball_visible), 0);
      waitCycles(1);
      checkOutput("settle.new_ball", 32'(new_ball), 0);
      checkOutput("settle.ball_visible", 32'(ball_visible), 0);
      waitCycles(1);
      checkOutput("active.ball_visible", 32'(ball_visible), 1);

      // Round 1: hit at the box's far corner in ACTIVE cycle 9 (2 ms)
      waitCycles(9);
      applyStimulus(1'b0, 1'b1, 139, 239);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 139, 239);
      checkOutput("hit1.score", 32'(score), 1);
      checkOutput("hit1.last_rt", 32'(last_rt), 2);
      checkOutput("hit1.best_rt", 32'(best_rt), 2);
      checkOutput("hit1.round_cnt", 32'(round_cnt), 1);
      checkOutput("hit1.ball_visible", 32'(ball_visible), 0);
      checkOutput("hit1.new_ball", 32'(new_ball), 1);

      // Round 2: click just outside the box, then time out
      waitCycles(2);
      checkOutput("r2.ball_visible", 32'(ball_visible), 1);
      applyStimulus(1'b0, 1'b1, 140, 200);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 140, 200);
      checkOutput("outside.ball_visible", 32'(ball_visible), 1);
      checkOutput("outside.score", 32'(score), 1);
      checkOutput("outside.round_cnt", 32'(round_cnt), 1);
      waitCycles(19);
      checkOutput("pretimeout.ball_visible", 32'(ball_visible), 1);
      checkOutput("pretimeout.round_cnt", 32'(round_cnt), 1);
      waitCycles(1);
      checkOutput("timeout.last_rt", 32'(last_rt), 5);
      checkOutput("timeout.round_cnt", 32'(round_cnt), 2);
      checkOutput("timeout.score", 32'(score), 32'(SCORE_AFTER_MISS));
      checkOutput("timeout.best_rt", 32'(best_rt), 2);
      checkOutput("timeout.new_ball", 32'(new_ball), 1);

      // Round 3: hit on the exact timeout cycle, ending the game
      waitCycles(2);
      waitCycles(20);
      checkOutput("r3.ball_visible", 32'(ball_visible), 1);
      applyStimulus(1'b0, 1'b1, 100, 200);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 100, 200);
      checkOutput("edgehit.score", 32'(SCORE_AFTER_MISS + 1), 32'(score));
      checkOutput("edgehit.last_rt", 32'(last_rt), 5);
      checkOutput("edgehit.best_rt", 32'(best_rt), 2);
      checkOutput("edgehit.round_cnt", 32'(round_cnt), 3);
      checkOutput("edgehit.game_over", 32'(game_over), 1);
      checkOutput("edgehit.ball_visible", 32'(ball_visible), 0);
      checkOutput("edgehit.new_ball", 32'(new_ball), 0);

      // DONE holds through an in-box click
      applyStimulus(1'b0, 1'b1, 110, 210);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 110, 210);
      waitCycles(1);
      checkOutput("done.score", 32'(score), 32'(SCORE_AFTER_MISS + 1));
      checkOutput("done.round_cnt", 32'(round_cnt), 3);
      checkOutput("done.game_over", 32'(game_over), 1);
      checkOutput("done.new_ball", 32'(new_ball), 0);

      // Restart from DONE clears the game
      applyStimulus(1'b1, 1'b0, 110, 210);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 110, 210);
      checkOutput("restart.score", 32'(score), 0);
      checkOutput("restart.round_cnt", 32'(round_cnt), 0);
      checkOutput("restart.last_rt", 32'(last_rt), 0);
      checkOutput("restart.best_rt", 32'(best_rt), 1023);
      checkOutput("restart.game_over", 32'(game_over), 0);
      checkOutput("restart.new_ball", 32'(new_ball), 1);

      // Immediate hit (0 ms), with a stray start ignored during ACTIVE
      waitCycles(2);
      applyStimulus(1'b1, 1'b0, 110, 210);
      waitCycles(1);
      applyStimulus(1'b0, 1'b1, 110, 210);
      checkOutput("ignstart.ball_visible", 32'(ball_visible), 1);
      checkOutput("ignstart.new_ball", 32'(new_ball), 0);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 110, 210);
      checkOutput("hit0.score", 32'(score), 1);
      checkOutput("hit0.last_rt", 32'(last_rt), 0);
      checkOutput("hit0.best_rt", 32'(best_rt), 0);

      // Second hit, then reset in ACTIVE with score 2
      waitCycles(2);
      applyStimulus(1'b0, 1'b1, 110, 210);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 110, 210);
      checkOutput("hit2.score", 32'(score), 2);
      checkOutput("hit2.round_cnt", 32'(round_cnt), 2);
      waitCycles(2);
      checkOutput("prerst.ball_visible", 32'(ball_visible), 1);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      checkReset("midrst");
      waitCycles(2);
      checkOutput("postrst.new_ball", 32'(new_ball), 0);
      checkOutput("postrst.ball_visible", 32'(ball_visible), 0);
      applyStimulus(1'b1, 1'b0, 110, 210);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0, 110, 210);
      checkOutput("postrst.start_new_ball", 32'(new_ball), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
